// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, flit types, port indices and
// arbiter state encoding used by the router arbiters.
package noc_pkg;

    localparam int FLIT_W = 32;

    localparam logic [1:0] FLIT_IDLE = 2'b00;
    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_BODY = 2'b10;
    localparam logic [1:0] FLIT_TAIL = 2'b11;

    localparam int PORT_N = 0;
    localparam int PORT_E = 1;
    localparam int PORT_S = 2;
    localparam int PORT_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first set req bit searching upward
// from rr_ptr+1 with wrap-around.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             any,
    output logic [IDX_W-1:0] winner
);

    logic [IDX_W-1:0] idx;

    // Walk farthest-to-nearest so the nearest match is the last write.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = IDX_W'((int'(rr_ptr) + i) % NREQ);
            if (req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/pe_eject_arbiter.sv
// Packet-level round-robin arbiter for the switch-to-PE ejection path,
// with a watchdog that releases an owner stalled mid-packet.
module pe_eject_arbiter #(
    parameter int NREQ    = 4,
    parameter int FLIT_W  = noc_pkg::FLIT_W,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*FLIT_W-1:0] flit_in,
    input  logic                   pe_ready,
    output logic [NREQ-1:0]        gnt,
    output logic [FLIT_W-1:0]      flit_out,
    output logic                   pe_enable,
    output logic                   timeout_err
);

    import noc_pkg::*;

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'(TIMEOUT - 1);

    arb_state_t       state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [CNT_W-1:0] idle_cnt;
    logic             any;
    logic [FLIT_W-1:0] flits [NREQ];
    logic [FLIT_W-1:0] own_flit;
    logic             accept;
    logic             is_tail;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            flits[i] = flit_in[i*FLIT_W +: FLIT_W];
        end
    end

    assign own_flit = flits[owner];
    assign accept   = req[owner] & pe_ready;
    assign is_tail  = own_flit[FLIT_W-1 -: 2] == FLIT_TAIL;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .any    (any),
        .winner (winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            owner       <= '0;
            rr_ptr      <= IDX_W'(NREQ - 1);
            idle_cnt    <= '0;
            gnt         <= '0;
            flit_out    <= '0;
            pe_enable   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            pe_enable   <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (any) begin
                        owner    <= winner;
                        gnt      <= NREQ'(1) << winner;
                        idle_cnt <= '0;
                        state    <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (accept) begin
                        flit_out  <= own_flit;
                        pe_enable <= 1'b1;
                        idle_cnt  <= '0;
                        if (is_tail) begin
                            gnt    <= '0;
                            rr_ptr <= owner;
                            state  <= ST_IDLE;
                        end
                    end else if (!req[owner]) begin
                        // Only a missing flit counts; PE back-pressure never times out.
                        if (idle_cnt == LAST_IDLE) begin
                            idle_cnt    <= '0;
                            gnt         <= '0;
                            rr_ptr      <= owner;
                            timeout_err <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            idle_cnt <= idle_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_eject_arbiter.sv
// Randomized and directed bench for pe_eject_arbiter against a
// packet-level reference model kept in the bench.
module tb_pe_eject_arbiter;

    localparam int NREQ = 4;
    localparam int FW   = 32;
    localparam int TO   = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*FW-1:0] flit_in;
    logic              pe_ready;
    logic [NREQ-1:0]   gnt;
    logic [FW-1:0]     flit_out;
    logic              pe_enable;
    logic              timeout_err;

    always #5 clk = ~clk;

    pe_eject_arbiter #(
        .NREQ    (NREQ),
        .FLIT_W  (FW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .flit_in     (flit_in),
        .pe_ready    (pe_ready),
        .gnt         (gnt),
        .flit_out    (flit_out),
        .pe_enable   (pe_enable),
        .timeout_err (timeout_err)
    );

    int checks = 0;
    int errors = 0;

    logic [FW-1:0]   pq [NREQ][$];
    logic [NREQ-1:0] mask;

    // Reference model: owner = -1 means nobody holds the path.
    int            m_owner;
    int            m_rr;
    int            m_idle;
    logic [FW-1:0] m_flit;
    logic          m_en;
    logic          m_err;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req[i] = mask[i] && (pq[i].size() > 0);
            flit_in[i*FW +: FW] = (pq[i].size() > 0) ? pq[i][0] : '0;
        end
    endtask

    task automatic push_pkt(int port, int len);
        for (int j = 0; j < len; j++) begin
            logic [1:0]    t;
            logic [FW-3:0] pl;
            if (j == len - 1) t = 2'b11;
            else if (j == 0) t = 2'b01;
            else t = 2'($urandom_range(0, 2));
            pl = (FW-2)'($urandom);
            pq[port].push_back({t, pl});
        end
    endtask

    task automatic step();
        int              p;
        logic [FW-1:0]   f;
        logic [NREQ-1:0] eg;
        m_en  = 1'b0;
        m_err = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_rr    = NREQ - 1;
            m_idle  = 0;
            m_flit  = '0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                p = (m_rr + k) % NREQ;
                if (m_owner < 0 && req[p]) begin
                    m_owner = p;
                    m_idle  = 0;
                end
            end
        end else if (req[m_owner] && pe_ready) begin
            f      = flit_in[m_owner*FW +: FW];
            m_flit = f;
            m_en   = 1'b1;
            m_idle = 0;
            void'(pq[m_owner].pop_front());
            if (f[FW-1:FW-2] == 2'b11) begin
                m_rr    = m_owner;
                m_owner = -1;
            end
        end else if (!req[m_owner]) begin
            m_idle++;
            if (m_idle == TO) begin
                m_idle  = 0;
                m_rr    = m_owner;
                m_owner = -1;
                m_err   = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk("gnt", 64'(gnt), 64'(eg));
        chk("pe_enable", 64'(pe_enable), 64'(m_en));
        chk("flit_out", 64'(flit_out), 64'(m_flit));
        chk("timeout_err", 64'(timeout_err), 64'(m_err));
        drive();
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NREQ; i++) pq[i].delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mask = '0;
        drive();
        step();
        rst = 1'b0;
    endtask

    logic [FW-1:0] hd;
    logic [FW-1:0] tl;

    initial begin
        rst      = 1'b1;
        pe_ready = 1'b1;
        mask     = '0;
        m_owner  = -1;
        m_rr     = NREQ - 1;
        m_idle   = 0;
        drive();
        step();
        step();
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_flit", 64'(flit_out), 64'h0);
        rst = 1'b0;

        // Single 3-flit packet on port 0.
        pq[0].push_back(32'h4000_0001);
        pq[0].push_back(32'h8000_0002);
        pq[0].push_back(32'hC000_0003);
        mask = 4'b0001;
        drive();
        step();
        chk("t1_gnt", 64'(gnt), 64'h1);
        chk("t1_en0", 64'(pe_enable), 64'h0);
        step();
        chk("t1_f0", 64'(flit_out), 64'h4000_0001);
        step();
        chk("t1_f1", 64'(flit_out), 64'h8000_0002);
        step();
        chk("t1_f2", 64'(flit_out), 64'hC000_0003);
        chk("t1_en", 64'(pe_enable), 64'h1);
        chk("t1_gnt_off", 64'(gnt), 64'h0);
        step();
        chk("t1_en_off", 64'(pe_enable), 64'h0);

        // All ports request 2-flit packets: order 0,1,2,3,0 with one bubble.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            push_pkt(i, 2);
            push_pkt(i, 2);
        end
        mask = 4'b1111;
        drive();
        for (int c = 0; c < 15; c++) begin
            logic [3:0] e;
            step();
            e = (c % 3 == 2) ? 4'b0 : 4'(1 << ((c / 3) % NREQ));
            chk("rr_gnt", 64'(gnt), 64'(e));
        end
        repeat (20) step();

        // Port 2 owns, PE stalls 5 cycles mid-packet.
        push_pkt(2, 4);
        hd = pq[2][0];
        tl = pq[2][3];
        mask = 4'b0100;
        drive();
        step();
        chk("st_gnt", 64'(gnt), 64'h4);
        step();
        pe_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("st_hold", 64'(flit_out), 64'(hd));
            chk("st_en", 64'(pe_enable), 64'h0);
            chk("st_to", 64'(timeout_err), 64'h0);
        end
        pe_ready = 1'b1;
        repeat (3) step();
        chk("st_tail", 64'(flit_out), 64'(tl));
        chk("st_gnt_off", 64'(gnt), 64'h0);

        // Port 1 goes silent after its head; port 2 waits.
        push_pkt(1, 3);
        push_pkt(2, 1);
        mask = 4'b0010;
        drive();
        step();
        chk("to_own", 64'(gnt), 64'h2);
        step();
        mask = 4'b0100;
        drive();
        for (int i = 1; i <= TO; i++) begin
            step();
            chk("to_err", 64'(timeout_err), 64'(i == TO));
            chk("to_gnt", 64'(gnt), (i == TO) ? 64'h0 : 64'h2);
        end
        step();
        chk("to_next", 64'(gnt), 64'h4);
        chk("to_pulse", 64'(timeout_err), 64'h0);
        step();
        pq[1].delete();

        // Reset while port 3 is mid-packet.
        push_pkt(3, 4);
        mask = 4'b1000;
        drive();
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("mr_gnt", 64'(gnt), 64'h0);
        chk("mr_en", 64'(pe_enable), 64'h0);
        chk("mr_flit", 64'(flit_out), 64'h0);
        chk("mr_to", 64'(timeout_err), 64'h0);
        rst = 1'b0;
        clear_queues();
        push_pkt(0, 1);
        push_pkt(3, 1);
        mask = 4'b1001;
        drive();
        step();
        chk("mr_first", 64'(gnt), 64'h1);
        step();
        step();
        chk("mr_second", 64'(gnt), 64'h8);
        step();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                int p;
                p = $urandom_range(0, NREQ - 1);
                if (pq[p].size() < 6) push_pkt(p, $urandom_range(1, 4));
            end
            for (int i = 0; i < NREQ; i++) mask[i] = ($urandom_range(0, 5) != 0);
            pe_ready = ($urandom_range(0, 3) != 0);
            drive();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_eject_arbiter.md
# pe_eject_arbiter

Packet-level round-robin arbiter that shares the single switch-to-PE ejection path of a router between its NREQ input ports (N, E, S, W by default). A requester wins the path at a packet boundary and keeps it until its tail flit is accepted. A watchdog releases an owner that stalls mid-packet. The arbiter sits between the router input buffers and `s2pe`. It drives the `s2pe` `enable`/`flit_in` pair and uses the `s2pe` `grant` output as its flow-control ready.

## Interface
- `NREQ`, default 4: number of requesting input ports; index 0 = N, 1 = E, 2 = S, 3 = W.
- `FLIT_W`, default 32: flit width; bits [FLIT_W-1:FLIT_W-2] carry the flit type.
- `TIMEOUT`, default 64: consecutive owner-idle cycles in LOCK before a forced release; must be ≥ 1.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, NREQ: per-port "flit available" flag.
- `flit_in`, in, NREQ*FLIT_W: port i flit at [i*FLIT_W +: FLIT_W].
- `pe_ready`, in, 1: `s2pe` grant; flit accepted only when high.
- `gnt`, out, NREQ: registered one-hot owner; pops the owner's buffer when `gnt[i] & req[i] & pe_ready`.
- `flit_out`, out, FLIT_W: registered flit to `s2pe` `flit_in`.
- `pe_enable`, out, 1: registered; high for exactly the cycles in which `flit_out` holds a new accepted flit (drives `s2pe` `enable`).
- `timeout_err`, out, 1: one-cycle pulse on a forced release.

## Operation
- Flit types in [31:30]:
  - 2'b00: idle.
  - 2'b01: head.
  - 2'b10: body.
  - 2'b11: tail.
  - A single-flit packet is a lone tail.
- State encoding: IDLE and LOCK. Registers:
  - `owner` (clog2(NREQ) bits).
  - `rr_ptr` (last owner).
  - `idle_cnt` (clog2(TIMEOUT+1) bits).
- Reset values:
  - state = IDLE.
  - `gnt` = 0, `pe_enable` = 0, `timeout_err` = 0.
  - `flit_out` = 0, `idle_cnt` = 0.
  - `rr_ptr` = NREQ-1, so port 0 has first priority.
- IDLE:
  - If `req` ≠ 0, pick the first set bit searching from `rr_ptr`+1 upward with wrap-around.
  - Then: `owner` ← winner; `gnt` ← one-hot(winner); state → LOCK.
  - If `req` = 0, remain in IDLE.
  - No flit is forwarded while in IDLE.
- LOCK, accept condition `req[owner] & pe_ready`:
  - `flit_out` ← owner's flit; `pe_enable` ← 1; `idle_cnt` ← 0.
  - If the accepted flit type is 2'b11: `gnt` ← 0; `rr_ptr` ← `owner`; state → IDLE.
- LOCK, no accept:
  - `pe_enable` ← 0; `flit_out` holds its value.
  - If `req[owner]` = 0: `idle_cnt` += 1; `pe_ready` = 0 alone does not count.
  - When `idle_cnt` would reach TIMEOUT: `gnt` ← 0; `rr_ptr` ← `owner`; `timeout_err` ← 1 for one cycle; state → IDLE.
- Non-owner `req` bits are ignored during LOCK.
- Flit type is not checked, except for tail detection.

## Timing
- Grant latency: `req` rises at edge t while IDLE → `gnt` valid after edge t+1. The first flit is accepted at edge t+2 if `pe_ready` is high, and `pe_enable`/`flit_out` are visible after that edge.
- Throughput: one flit per cycle while `req[owner]` and `pe_ready` are both high.
- Tail accepted at edge k: `gnt` = 0 after k. IDLE arbitrates at edge k+1, so the next grant appears after k+1. This gives exactly one bubble between packets, even when other requests are pending.
- Tail acceptance and timeout in the same cycle cannot occur, because acceptance resets `idle_cnt`. The tail path takes precedence.
- `rst` mid-packet: all registers return to reset values on that edge. The partial packet is abandoned, and `timeout_err` is not pulsed.
- A zero-width `req` is not allowed; NREQ must be ≥ 2.

## Structure
- Shared package `noc_pkg`:
  - `FLIT_W`.
  - Flit-type constants `FLIT_IDLE`/`FLIT_HEAD`/`FLIT_BODY`/`FLIT_TAIL`.
  - Port index constants `PORT_N`/`PORT_E`/`PORT_S`/`PORT_W`.
  - State encodings.
- One sub-module, `rr_pick`: combinational rotate-priority picker. Inputs: `req`, `rr_ptr`. Outputs: `any`, winner index. Reused by the router output arbiters.

## Test plan
- Reset, then `req`=4'b0001 and port 0 sends head/body/tail 0x4000_0001, 0x8000_0002, 0xC000_0003 with `pe_ready`=1:
  - `gnt`=0001 one cycle after `req`.
  - `pe_enable` high for 3 cycles, `flit_out` in that order.
  - `gnt`=0 after the tail.
- `req`=4'b1111 held, every port sends 2-flit packets: grants go in order 0,1,2,3,0, with one bubble cycle between packets.
- Port 2 owns; `pe_ready` is low for 5 cycles mid-packet: `flit_out` is held, `pe_enable`=0, no timeout, and the packet completes intact.
- Port 1 owns and drops `req` after the head for TIMEOUT=64 cycles:
  - `timeout_err` pulses once at cycle 64.
  - `gnt`=0.
  - The next grant goes to port 2 if it is requesting.
- `rst` asserted while port 3 is mid-packet:
  - Next cycle all outputs are 0.
  - With `req`=4'b1001, port 0 is granted first.
